// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the writeback slice: load funct3 encodings
// and the writeback FSM state encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// MEM->WB handshake, data-memory read response and regfile write/forward bus.
// master = MEM stage / memory side, slave = writeback unit.
interface wb_unit_if;
  logic        m_valid;
  logic        m_ready;
  logic        m_reg_write;
  logic        m_is_load;
  logic [4:0]  m_rd;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        load_err;
  logic [31:0] instret;

  modport master (
    output m_valid, m_reg_write, m_is_load, m_rd, m_funct3, m_addr_lo,
           m_alu_result, dmem_rvalid, dmem_rdata,
    input  m_ready, rf_we, rf_rd, rf_wd, load_err, instret
  );

  modport slave (
    input  m_valid, m_reg_write, m_is_load, m_rd, m_funct3, m_addr_lo,
           m_alu_result, dmem_rvalid, dmem_rdata,
    output m_ready, rf_we, rf_rd, rf_wd, load_err, instret
  );
endinterface

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/halfword selected by the
// address offset, sign- or zero-extends it, and flags misaligned or
// illegal funct3 encodings.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lanes[offset];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  // Width/sign decode; illegal encodings return zero data with err set.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = offset[0];
      end
      F3_LHU: begin
        data = {16'h0, half_sel};
        err  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (offset != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: retires MEM-stage instructions, waits for load data,
// drives the single regfile write port (also the WB->EX forwarding bus)
// and counts retired instructions.
module wb_unit
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_unit_if.slave   bus
);

  wb_state_e   state_reg, state_next;

  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic        reg_write_reg;

  logic        rf_we_reg;
  logic [4:0]  rf_rd_reg;
  logic [31:0] rf_wd_reg;
  logic        load_err_reg;
  logic [31:0] instret_reg;

  logic        in_idle;
  logic        accept_alu, accept_load, accept_bad, load_done;
  logic [2:0]  align_f3;
  logic [1:0]  align_off;
  logic [31:0] align_data;
  logic        align_err;

  assign in_idle = (state_reg == WB_IDLE);

  // One aligner serves both jobs: in IDLE it checks the incoming load for
  // errors, in WAIT_LOAD it extracts data using the captured fields.
  assign align_f3  = in_idle ? bus.m_funct3  : funct3_reg;
  assign align_off = in_idle ? bus.m_addr_lo : off_reg;

  load_align u_align (
    .funct3 (align_f3),
    .offset (align_off),
    .rdata  (bus.dmem_rdata),
    .data   (align_data),
    .err    (align_err)
  );

  assign accept_alu  = in_idle && bus.m_valid && !bus.m_is_load;
  assign accept_load = in_idle && bus.m_valid &&  bus.m_is_load && !align_err;
  assign accept_bad  = in_idle && bus.m_valid &&  bus.m_is_load &&  align_err;
  assign load_done   = (state_reg == WB_WAIT_LOAD) && bus.dmem_rvalid;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= WB_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state: only legal loads leave IDLE; rvalid returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WB_IDLE:      if (accept_load) state_next = WB_WAIT_LOAD;
      WB_WAIT_LOAD: if (bus.dmem_rvalid) state_next = WB_IDLE;
      default:      state_next = WB_IDLE;
    endcase
  end

  // FSM outputs: ready depends on state only, never on m_valid.
  always_comb begin
    bus.m_ready = (state_reg == WB_IDLE);
  end

  // Capture the fields of an accepted load for use when data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg        <= '0;
      funct3_reg    <= '0;
      off_reg       <= '0;
      reg_write_reg <= 1'b0;
    end else if (accept_load) begin
      rd_reg        <= bus.m_rd;
      funct3_reg    <= bus.m_funct3;
      off_reg       <= bus.m_addr_lo;
      reg_write_reg <= bus.m_reg_write;
    end
  end

  // Regfile write port, error pulse and retire counter. rf_rd/rf_wd only
  // change on an actual write so forwarding consumers see stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_rd_reg    <= '0;
      rf_wd_reg    <= '0;
      load_err_reg <= 1'b0;
      instret_reg  <= '0;
    end else begin
      rf_we_reg    <= 1'b0;
      load_err_reg <= accept_bad;
      if (accept_alu) begin
        instret_reg <= instret_reg + 32'd1;
        if (bus.m_reg_write && (bus.m_rd != 5'd0)) begin
          rf_we_reg <= 1'b1;
          rf_rd_reg <= bus.m_rd;
          rf_wd_reg <= bus.m_alu_result;
        end
      end else if (load_done) begin
        instret_reg <= instret_reg + 32'd1;
        if (reg_write_reg && (rd_reg != 5'd0)) begin
          rf_we_reg <= 1'b1;
          rf_rd_reg <= rd_reg;
          rf_wd_reg <= align_data;
        end
      end
    end
  end

  assign bus.rf_we    = rf_we_reg;
  assign bus.rf_rd    = rf_rd_reg;
  assign bus.rf_wd    = rf_wd_reg;
  assign bus.load_err = load_err_reg;
  assign bus.instret  = instret_reg;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a table of single-instruction vectors
// plus hand-written sequences for back-to-back retire, delayed rvalid,
// rvalid while idle and reset during a pending load.
module tb_wb_unit;

  logic clk;
  logic rst;

  wb_unit_if bus ();

  wb_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] RDATA = 32'h80F1_7F82;

  typedef struct {
    logic        is_load;
    logic        reg_write;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] alu;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_wd = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.m_valid      = 1'b0;
    bus.m_reg_write  = 1'b0;
    bus.m_is_load    = 1'b0;
    bus.m_rd         = 5'd0;
    bus.m_funct3     = 3'd0;
    bus.m_addr_lo    = 2'd0;
    bus.m_alu_result = 32'd0;
    bus.dmem_rvalid  = 1'b0;
    bus.dmem_rdata   = 32'd0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " rf_rd"},    {27'd0, bus.rf_rd}, {27'd0, last_rd});
    check({tag, " rf_wd"},    bus.rf_wd, last_wd);
    check({tag, " instret"},  bus.instret, exp_instret);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    bus.m_valid      = 1'b1;
    bus.m_is_load    = v.is_load;
    bus.m_reg_write  = v.reg_write;
    bus.m_rd         = v.rd;
    bus.m_funct3     = v.f3;
    bus.m_addr_lo    = v.off;
    bus.m_alu_result = v.alu;
    check("vec m_ready before accept", {31'd0, bus.m_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    if (v.is_load && !v.exp_err) begin
      check("vec m_ready waiting", {31'd0, bus.m_ready}, 32'd0);
      check("vec rf_we waiting",   {31'd0, bus.rf_we},   32'd0);
      @(negedge clk);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = RDATA;
      @(posedge clk);
      #1;
      bus.dmem_rvalid = 1'b0;
    end
    if (!v.exp_err) exp_instret = exp_instret + 32'd1;
    if (v.exp_we) begin
      last_rd = v.rd;
      last_wd = v.exp_wd;
    end
    check("vec rf_we",    {31'd0, bus.rf_we},    {31'd0, v.exp_we});
    check("vec load_err", {31'd0, bus.load_err}, {31'd0, v.exp_err});
    check("vec m_ready after", {31'd0, bus.m_ready}, 32'd1);
    check_outputs("vec");
    $display("vec %0d: load=%0d f3=%0d off=%0d rd=%0d -> we=%0d rd=%0d wd=0x%08h err=%0d instret=%0d",
             i, v.is_load, v.f3, v.off, v.rd, bus.rf_we, bus.rf_rd, bus.rf_wd, bus.load_err, bus.instret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                load rw rd     f3      off    alu           we  exp_wd        err
    vecs[0]  = '{1'b0, 1'b1, 5'd3,  3'b000, 2'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  3'b000, 2'd0, 32'h0,        1'b1, 32'hFFFFFF82, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd6,  3'b100, 2'd0, 32'h0,        1'b1, 32'h00000082, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 5'd7,  3'b000, 2'd1, 32'h0,        1'b1, 32'h0000007F, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd8,  3'b001, 2'd2, 32'h0,        1'b1, 32'hFFFF80F1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd9,  3'b101, 2'd2, 32'h0,        1'b1, 32'h000080F1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd10, 3'b010, 2'd0, 32'h0,        1'b1, 32'h80F17F82, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd11, 3'b010, 2'd1, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b1, 5'd11, 3'b110, 2'd0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b1, 5'd11, 3'b001, 2'd1, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b1, 5'd0,  3'b000, 2'd0, 32'h12345678, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b1, 5'd0,  3'b010, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b0, 5'd4,  3'b000, 2'd0, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd14, 3'b100, 2'd3, 32'h0,        1'b1, 32'h00000080, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 5'd15, 3'b000, 2'd3, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 5'd16, 3'b001, 2'd0, 32'h0,        1'b1, 32'h00007F82, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 5'd17, 3'b101, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[17] = '{1'b1, 1'b1, 5'd18, 3'b011, 2'd0, 32'h0,        1'b0, 32'h0,        1'b1};

    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset rf_we",    {31'd0, bus.rf_we},    32'd0);
    check("reset load_err", {31'd0, bus.load_err}, 32'd0);
    check("reset m_ready",  {31'd0, bus.m_ready},  32'd1);
    check_outputs("reset");
    $display("reset: we=%0d rd=%0d wd=0x%08h instret=%0d", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.instret);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Back-to-back ALU retires to x1, x2, x3.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.m_valid      = 1'b1;
      bus.m_is_load    = 1'b0;
      bus.m_reg_write  = 1'b1;
      bus.m_rd         = 5'(k);
      bus.m_alu_result = 32'h0000_0100 + 32'(k);
      check("b2b m_ready", {31'd0, bus.m_ready}, 32'd1);
      @(posedge clk);
      #1;
      exp_instret = exp_instret + 32'd1;
      last_rd = 5'(k);
      last_wd = 32'h0000_0100 + 32'(k);
      check("b2b rf_we", {31'd0, bus.rf_we}, 32'd1);
      check_outputs("b2b");
      $display("b2b x%0d: we=%0d rd=%0d wd=0x%08h", k, bus.rf_we, bus.rf_rd, bus.rf_wd);
    end
    @(negedge clk);
    bus.m_valid = 1'b0;

    // Load whose rvalid arrives three cycles after accept.
    @(negedge clk);
    bus.m_valid     = 1'b1;
    bus.m_is_load   = 1'b1;
    bus.m_reg_write = 1'b1;
    bus.m_rd        = 5'd12;
    bus.m_funct3    = 3'b010;
    bus.m_addr_lo   = 2'd0;
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("delay m_ready", {31'd0, bus.m_ready}, 32'd0);
      check("delay rf_we",   {31'd0, bus.rf_we},   32'd0);
      if (k == 2) begin
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1234_5678;
      end
      @(posedge clk);
      #1;
    end
    bus.dmem_rvalid = 1'b0;
    exp_instret = exp_instret + 32'd1;
    last_rd = 5'd12;
    last_wd = 32'h1234_5678;
    check("delay rf_we done",   {31'd0, bus.rf_we},   32'd1);
    check("delay m_ready done", {31'd0, bus.m_ready}, 32'd1);
    check_outputs("delay");
    $display("delayed load: we=%0d rd=%0d wd=0x%08h instret=%0d", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.instret);

    // rvalid while idle must be ignored.
    @(negedge clk);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b0;
    check("idle rvalid rf_we", {31'd0, bus.rf_we}, 32'd0);
    check_outputs("idle rvalid");
    $display("idle rvalid: we=%0d instret=%0d", bus.rf_we, bus.instret);

    // Reset while a load is pending; a late rvalid must not write.
    @(negedge clk);
    bus.m_valid     = 1'b1;
    bus.m_is_load   = 1'b1;
    bus.m_reg_write = 1'b1;
    bus.m_rd        = 5'd13;
    bus.m_funct3    = 3'b010;
    bus.m_addr_lo   = 2'd0;
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    check("rstwait m_ready before", {31'd0, bus.m_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_instret = 32'd0;
    last_rd = 5'd0;
    last_wd = 32'd0;
    check("rstwait rf_we",    {31'd0, bus.rf_we},    32'd0);
    check("rstwait load_err", {31'd0, bus.load_err}, 32'd0);
    check("rstwait m_ready",  {31'd0, bus.m_ready},  32'd1);
    check_outputs("rstwait");
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b0;
    check("late rvalid rf_we",   {31'd0, bus.rf_we},   32'd0);
    check("late rvalid m_ready", {31'd0, bus.m_ready}, 32'd1);
    check_outputs("late rvalid");
    $display("reset mid-load: we=%0d rd=%0d wd=0x%08h instret=%0d", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.instret);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
